forward_ctrl: RTL and testbench
===============================

FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 4, giving the register-address width (16 architectural registers).
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have a port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have a port issue_valid, input, 1 bit: an instruction is entering EX this cycle.
REQ-005 The block SHALL have a port issue_wen, input, 1 bit: the issuing instruction writes a register.
REQ-006 The block SHALL have a port issue_load, input, 1 bit: the issuing instruction is a memory load.
REQ-007 The block SHALL have a port issue_rd, input, REG_AW bits: destination of the issuing instruction.
REQ-008 The block SHALL have ports src_a and src_b, input, REG_AW bits each: source registers of the instruction in decode.
REQ-009 The block SHALL have a port flush, input, 1 bit: kill the instruction entering EX.
REQ-010 The block SHALL have ports sel_a and sel_b, output, 2 bits each: operand select for the ALU operand mux.
REQ-011 The block SHALL have a port hazard_stall, output, 1 bit: load-use stall request to decode.
REQ-012 The block SHALL have a port stall_count, output, 16 bits: saturating count of hazard_stall cycles.

Function
REQ-013 sel encoding SHALL be:
- 2'd0: forward from EX_data.
- 2'd1: forward from MEM_data.
- 2'd2: forward from WB_data.
- 2'd3: no forward (register-file operand).
REQ-014 State SHALL be three stage slots EX, MEM and WB, each holding valid, wen, load and rd.
REQ-015 Each clock, the stages SHALL advance: WB<=MEM and MEM<=EX.
REQ-016 Each clock, EX SHALL be loaded from the issue_* inputs when issue_valid=1, flush=0 and hazard_stall=0; otherwise EX SHALL load a bubble (valid=0).
REQ-017 flush and hazard_stall SHALL NOT freeze MEM or WB; those stages always advance.
REQ-018 A stage SHALL match source s when valid=1, wen=1, rd==s and s!=0.
- Register 0 never forwards.
REQ-019 sel_a and sel_b SHALL be combinational from the stage state and src_a/src_b, with zero-cycle latency.
- Priority is EX (0) > MEM (1) > WB (2) > none (3), so the youngest producer wins.
REQ-020 hazard_stall SHALL be 1 when EX matches src_a or src_b and the EX load bit is 1; otherwise 0.
REQ-021 While hazard_stall=1, the sel for the EX-matched operand SHALL still report 2'd0.
- Decode ignores the sel value during a stall.
- On the next cycle, the load has moved to MEM and sel reports 2'd1.
REQ-022 stall_count SHALL increment by 1 on each clock with hazard_stall=1 and SHALL saturate at 16'hFFFF.
REQ-023 When flush=1 and hazard_stall=1 occur in the same cycle, EX SHALL receive a bubble, and stall_count SHALL still increment.

Reset
REQ-024 On rst=1, regardless of clk, all stage valid bits SHALL clear and stall_count SHALL clear to 0.
REQ-025 While rst=1 (and in the cycle after release), sel_a and sel_b SHALL be 2'd3 and hazard_stall SHALL be 0.
REQ-026 rst asserted mid-stream SHALL discard all in-flight destinations.
- No forward is reported after release until new issues arrive.

Verification
REQ-027 Issue r3 (wen=1) at cycle 0 with no further issues; hold src_a=3 -> sel_a=0 at cycle 1, 1 at cycle 2, 2 at cycle 3, 3 at cycle 4.
REQ-028 Issue r5 at cycles 0 and 1; hold src_b=5 -> sel_b=0 at cycle 2 (younger producer wins), then 1 at cycle 3.
REQ-029 Issue a load to r7 at cycle 0; set src_a=7 at cycle 1 -> hazard_stall=1 for exactly one cycle and stall_count=1, then sel_a=1 with hazard_stall=0.
REQ-030 Issue to r0 with wen=1; src_a=0 -> sel_a stays 3 in all cycles; issue to r4 with wen=0 and src_a=4 -> sel_a=3.
REQ-031 Issue r2 together with flush=1; src_a=2 -> sel_a=3 on every following cycle; a second test asserts rst while r2 is in MEM -> sel_a=3 immediately and stall_count=0.
REQ-032 Force 65536 load-use stall cycles -> stall_count holds 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/forward_ctrl.sv
// Operand-forwarding and load-use hazard control for a 3-slot (EX/MEM/WB) pipeline.
// One forward_sel instance per ALU operand picks the youngest matching producer.

module forward_sel #(
   parameter int REG_AW = 4
) (
   input  logic              ex_fwd,
   input  logic              mem_fwd,
   input  logic              wb_fwd,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [REG_AW-1:0] src,
   output logic [1:0]        sel,
   output logic              ex_hit
);
   logic nz, mem_hit, wb_hit;

   always_comb begin
      nz      = |src;
      ex_hit  = ex_fwd  & nz & (ex_rd  == src);
      mem_hit = mem_fwd & nz & (mem_rd == src);
      wb_hit  = wb_fwd  & nz & (wb_rd  == src);
      sel     = 2'd3;
      if (ex_hit)       sel = 2'd0;
      else if (mem_hit) sel = 2'd1;
      else if (wb_hit)  sel = 2'd2;
   end
endmodule

module forward_ctrl #(
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              issue_wen,
   input  logic              issue_load,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic [REG_AW-1:0] src_a,
   input  logic [REG_AW-1:0] src_b,
   input  logic              flush,
   output logic [1:0]        sel_a,
   output logic [1:0]        sel_b,
   output logic              hazard_stall,
   output logic [15:0]       stall_count
);
   typedef struct packed {
      logic              valid;
      logic              wen;
      logic              load;
      logic [REG_AW-1:0] rd;
   } stage_t;

   stage_t ex_q, mem_q, wb_q;
   stage_t ex_d;

   logic [1:0][REG_AW-1:0] src;
   logic [1:0][1:0]        sel;
   logic [1:0]             ex_hit;

   assign src = {src_b, src_a};

   forward_sel #(.REG_AW(REG_AW)) u_sel [1:0] (
      .ex_fwd  (ex_q.valid  & ex_q.wen),
      .mem_fwd (mem_q.valid & mem_q.wen),
      .wb_fwd  (wb_q.valid  & wb_q.wen),
      .ex_rd   (ex_q.rd),
      .mem_rd  (mem_q.rd),
      .wb_rd   (wb_q.rd),
      .src     (src),
      .sel     (sel),
      .ex_hit  (ex_hit)
   );

   assign sel_a        = sel[0];
   assign sel_b        = sel[1];
   // A load in EX has no data yet, so any consumer of it must wait one cycle.
   assign hazard_stall = ex_q.load & (|ex_hit);

   always_comb begin
      ex_d = '0;
      if (issue_valid && !flush && !hazard_stall) begin
         ex_d.valid = 1'b1;
         ex_d.wen   = issue_wen;
         ex_d.load  = issue_load;
         ex_d.rd    = issue_rd;
      end
   end

   // MEM and WB always advance; only the EX slot is gated by flush/stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_count <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
         if (hazard_stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: forwarding priority, load-use stall, flush,
// reset behaviour and stall counter saturation.

module tb_forward_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid, issue_wen, issue_load;
   logic [3:0] issue_rd, src_a, src_b;
   logic       flush;
   logic [1:0] sel_a, sel_b;
   logic       hazard_stall;
   logic [15:0] stall_count;

   int checks = 0;
   int failures = 0;

   forward_ctrl #(.REG_AW(4)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_load(issue_load),
      .issue_rd(issue_rd), .src_a(src_a), .src_b(src_b), .flush(flush),
      .sel_a(sel_a), .sel_b(sel_b), .hazard_stall(hazard_stall),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_wen = 1'b0; issue_load = 1'b0; issue_rd = 4'd0;
      flush = 1'b0;
   endtask

   task automatic issue(input logic [3:0] rd, input logic wen, input logic ld);
      issue_valid = 1'b1; issue_wen = wen; issue_load = ld; issue_rd = rd;
   endtask

   task automatic do_reset();
      idle();
      src_a = 4'd0; src_b = 4'd0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      src_a = 4'd3; src_b = 4'd5;
      issue(4'd3, 1'b1, 1'b1);
      tick(); tick();
      checks++; if (sel_a !== 2'd3) begin failures++; $display("FAIL reset_sel_a: got %0d want 3", sel_a); end
      checks++; if (sel_b !== 2'd3) begin failures++; $display("FAIL reset_sel_b: got %0d want 3", sel_b); end
      checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0b want 0", hazard_stall); end
      checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", stall_count); end
      idle();
      rst = 1'b0;
      #1;
      checks++; if (sel_a !== 2'd3) begin failures++; $display("FAIL reset_release_sel_a: got %0d want 3", sel_a); end
   endtask

   task automatic test_age_out();
      do_reset();
      src_a = 4'd3;
      issue(4'd3, 1'b1, 1'b0);
      tick(); idle();
      checks++; if (sel_a !== 2'd0) begin failures++; $display("FAIL age_ex: got %0d want 0", sel_a); end
      tick();
      checks++; if (sel_a !== 2'd1) begin failures++; $display("FAIL age_mem: got %0d want 1", sel_a); end
      tick();
      checks++; if (sel_a !== 2'd2) begin failures++; $display("FAIL age_wb: got %0d want 2", sel_a); end
      tick();
      checks++; if (sel_a !== 2'd3) begin failures++; $display("FAIL age_none: got %0d want 3", sel_a); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      src_b = 4'd5;
      issue(4'd5, 1'b1, 1'b0);
      tick();
      issue(4'd5, 1'b1, 1'b0);
      tick(); idle();
      checks++; if (sel_b !== 2'd0) begin failures++; $display("FAIL b2b_ex_over_mem: got %0d want 0", sel_b); end
      tick();
      checks++; if (sel_b !== 2'd1) begin failures++; $display("FAIL b2b_mem_over_wb: got %0d want 1", sel_b); end
      checks++; if (sel_a !== 2'd3) begin failures++; $display("FAIL b2b_sel_a_r0: got %0d want 3", sel_a); end
      tick();
      checks++; if (sel_b !== 2'd2) begin failures++; $display("FAIL b2b_wb: got %0d want 2", sel_b); end
   endtask

   task automatic test_load_use();
      do_reset();
      issue(4'd7, 1'b1, 1'b1);
      tick();
      // issue during the stall must be dropped
      issue(4'd9, 1'b1, 1'b0);
      src_a = 4'd7;
      #1;
      checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL lu_stall: got %0b want 1", hazard_stall); end
      checks++; if (sel_a !== 2'd0) begin failures++; $display("FAIL lu_sel_ex: got %0d want 0", sel_a); end
      tick(); idle();
      src_b = 4'd9;
      #1;
      checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL lu_stall_clear: got %0b want 0", hazard_stall); end
      checks++; if (sel_a !== 2'd1) begin failures++; $display("FAIL lu_sel_mem: got %0d want 1", sel_a); end
      checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL lu_count: got %0d want 1", stall_count); end
      checks++; if (sel_b !== 2'd3) begin failures++; $display("FAIL lu_dropped_issue: got %0d want 3", sel_b); end
      // load-use on operand b, with flush in the same cycle
      src_a = 4'd0; src_b = 4'd0;
      issue(4'd6, 1'b1, 1'b1);
      tick();
      src_b = 4'd6;
      issue(4'd8, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL lu_b_stall: got %0b want 1", hazard_stall); end
      tick(); idle();
      src_a = 4'd8;
      #1;
      checks++; if (stall_count !== 16'd2) begin failures++; $display("FAIL flush_stall_count: got %0d want 2", stall_count); end
      checks++; if (sel_a !== 2'd3) begin failures++; $display("FAIL flush_stall_bubble: got %0d want 3", sel_a); end
      checks++; if (sel_b !== 2'd1) begin failures++; $display("FAIL lu_b_sel_mem: got %0d want 1", sel_b); end
   endtask

   task automatic test_no_forward();
      do_reset();
      src_a = 4'd0;
      issue(4'd0, 1'b1, 1'b0);
      tick(); idle();
      for (int i = 0; i < 3; i++) begin
         checks++; if (sel_a !== 2'd3) begin failures++; $display("FAIL r0_cycle%0d: got %0d want 3", i, sel_a); end
         tick();
      end
      src_a = 4'd4;
      issue(4'd4, 1'b0, 1'b1);
      tick(); idle();
      checks++; if (sel_a !== 2'd3) begin failures++; $display("FAIL nowen_sel: got %0d want 3", sel_a); end
      checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL nowen_stall: got %0b want 0", hazard_stall); end
   endtask

   task automatic test_flush_and_midreset();
      do_reset();
      src_a = 4'd2;
      issue(4'd2, 1'b1, 1'b0);
      flush = 1'b1;
      tick(); idle();
      for (int i = 0; i < 3; i++) begin
         checks++; if (sel_a !== 2'd3) begin failures++; $display("FAIL flush_cycle%0d: got %0d want 3", i, sel_a); end
         tick();
      end
      // build a nonzero stall count, then r2 reaches MEM and reset hits
      issue(4'd2, 1'b1, 1'b1);
      tick(); idle();
      tick();
      checks++; if (sel_a !== 2'd1) begin failures++; $display("FAIL midrst_pre: got %0d want 1", sel_a); end
      checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL midrst_pre_count: got %0d want 1", stall_count); end
      #2 rst = 1'b1;
      #1;
      checks++; if (sel_a !== 2'd3) begin failures++; $display("FAIL midrst_sel: got %0d want 3", sel_a); end
      checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL midrst_count: got %0d want 0", stall_count); end
      tick();
      rst = 1'b0;
      tick();
      checks++; if (sel_a !== 2'd3) begin failures++; $display("FAIL midrst_after: got %0d want 3", sel_a); end
   endtask

   task automatic test_saturation();
      do_reset();
      src_a = 4'd7;
      issue(4'd7, 1'b1, 1'b1);
      // each load is accepted, stalls once, then a bubble: one stall per 2 clocks
      repeat (200) tick();
      checks++; if (stall_count !== 16'd100) begin failures++; $display("FAIL sat_rate: got %0d want 100", stall_count); end
      repeat (2 * 65534 - 200) tick();
      checks++; if (stall_count !== 16'hFFFE) begin failures++; $display("FAIL sat_near: got %0h want fffe", stall_count); end
      repeat (2) tick();
      checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_max: got %0h want ffff", stall_count); end
      repeat (10) tick();
      checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold: got %0h want ffff", stall_count); end
      idle();
   endtask

   initial begin
      rst = 1'b0; src_a = 4'd0; src_b = 4'd0;
      idle();
      test_reset();
      test_age_out();
      test_back_to_back();
      test_load_use();
      test_no_forward();
      test_flush_and_midreset();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
